// File: rtl/surf_cout_align_ctrl.sv
// Training controller for one SURF COUT lane: IDELAY eye scan, centring and nybble bitslip alignment.
// Optional per-tap pass bitmap on eye_map_o when COUT_ALIGN_EYE_MAP_EN is defined.
module surf_cout_align_ctrl #(
  parameter logic [3:0] TRAIN_PATTERN = 4'hC,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         CHECK_CYCLES  = 64,
  parameter int         MIN_EYE       = 4
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        sync_i,
  input  logic [3:0]  cout_i,
  output logic        iserdes_rst_o,
  output logic [4:0]  idelay_value_o,
  output logic        idelay_load_o,
  output logic        bitslip_o,
  output logic        busy_o,
  output logic        locked_o,
  output logic        fail_o,
  output logic [4:0]  eye_start_o,
  output logic [5:0]  eye_len_o,
  output logic [31:0] eye_map_o
);

  typedef enum logic [3:0] {
    IDLE, RST, WAIT_SYNC, LOAD, SETTLE, CHECK, NEXT, CALC,
    CLOAD, CSETTLE, SCHECK, SLIP, SWAIT, LOCKED, FAIL
  } state_t;

  localparam logic [9:0] SET_LAST = 10'(SETTLE_CYCLES - 1);
  localparam logic [9:0] CHK_LAST = 10'(CHECK_CYCLES - 1);
  localparam logic [5:0] MIN_LEN  = 6'(MIN_EYE);

  state_t     state, state_n;
  logic [9:0] cnt, cnt_n;
  logic [4:0] tap, tap_n;
  logic [1:0] slips, slips_n;
  logic [3:0] ref_nyb, ref_nyb_n;
  logic       ok, ok_n;
  logic [5:0] cur_len, cur_len_n, best_len, best_len_n, eye_len_n;
  logic [4:0] cur_start, cur_start_n, best_start, best_start_n, eye_start_n;
  logic       start_ok, chk_ok, exact_ok;
  logic [5:0] new_len;
  logic [4:0] new_start, centre;
`ifdef COUT_ALIGN_EYE_MAP_EN
  logic [31:0] map, map_n;
`endif

  function automatic logic is_rot(input logic [3:0] v);
    return (v == TRAIN_PATTERN) ||
           (v == {TRAIN_PATTERN[2:0], TRAIN_PATTERN[3]}) ||
           (v == {TRAIN_PATTERN[1:0], TRAIN_PATTERN[3:2]}) ||
           (v == {TRAIN_PATTERN[0], TRAIN_PATTERN[3:1]});
  endfunction

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    tap_n        = tap;
    slips_n      = slips;
    ref_nyb_n    = ref_nyb;
    ok_n         = ok;
    cur_len_n    = cur_len;
    cur_start_n  = cur_start;
    best_len_n   = best_len;
    best_start_n = best_start;
    eye_len_n    = eye_len_o;
    eye_start_n  = eye_start_o;
`ifdef COUT_ALIGN_EYE_MAP_EN
    map_n        = map;
`endif
    start_ok  = start_i && (state == IDLE || state == LOCKED || state == FAIL);
    // Window verdicts include the sample taken on the current cycle.
    chk_ok    = (cnt == 10'd0) ? is_rot(cout_i) : (ok && (cout_i == ref_nyb));
    exact_ok  = (cout_i == TRAIN_PATTERN) && ((cnt == 10'd0) || ok);
    new_len   = ok ? cur_len + 6'd1 : 6'd0;
    new_start = (ok && cur_len == 6'd0) ? tap : cur_start;
    centre    = best_start + 5'((best_len - 6'd1) >> 1);

    case (state)
      IDLE, LOCKED, FAIL: begin
        if (start_ok) begin
          state_n      = RST;
          cur_len_n    = '0;
          cur_start_n  = '0;
          best_len_n   = '0;
          best_start_n = '0;
          eye_len_n    = '0;
          eye_start_n  = '0;
`ifdef COUT_ALIGN_EYE_MAP_EN
          map_n        = '0;
`endif
        end
      end
      RST: state_n = WAIT_SYNC;
      WAIT_SYNC: begin
        if (sync_i) begin
          tap_n   = '0;
          state_n = LOAD;
        end
      end
      LOAD, CLOAD: begin
        cnt_n   = '0;
        state_n = (state == LOAD) ? SETTLE : CSETTLE;
      end
      SETTLE, CSETTLE: begin
        if (cnt == SET_LAST) begin
          cnt_n   = '0;
          slips_n = '0;
          state_n = (state == SETTLE) ? CHECK : SCHECK;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      CHECK: begin
        ok_n = chk_ok;
        if (cnt == 10'd0) ref_nyb_n = cout_i;
        if (cnt == CHK_LAST) begin
          cnt_n   = '0;
          state_n = NEXT;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      NEXT: begin
        cur_len_n   = new_len;
        cur_start_n = new_start;
        // Strict compare keeps the earliest of equal-length runs.
        if (new_len > best_len) begin
          best_len_n   = new_len;
          best_start_n = new_start;
        end
`ifdef COUT_ALIGN_EYE_MAP_EN
        map_n[tap] = ok;
`endif
        if (tap == 5'd31) begin
          state_n = CALC;
        end else begin
          tap_n   = tap + 5'd1;
          state_n = LOAD;
        end
      end
      CALC: begin
        eye_start_n = best_start;
        eye_len_n   = best_len;
        if (best_len < MIN_LEN) begin
          state_n = FAIL;
        end else begin
          tap_n   = centre;
          state_n = CLOAD;
        end
      end
      SCHECK: begin
        ok_n = exact_ok;
        if (cnt == CHK_LAST) begin
          cnt_n = '0;
          if (exact_ok)            state_n = LOCKED;
          else if (slips == 2'd3)  state_n = FAIL;
          else                     state_n = SLIP;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      SLIP: begin
        slips_n = slips + 2'd1;
        cnt_n   = '0;
        state_n = SWAIT;
      end
      SWAIT: begin
        if (cnt == 10'd3) begin
          cnt_n   = '0;
          state_n = SCHECK;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobes and status are registered from the next state so they line up with it.
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      tap           <= '0;
      slips         <= '0;
      ref_nyb       <= '0;
      ok            <= 1'b0;
      cur_len       <= '0;
      cur_start     <= '0;
      best_len      <= '0;
      best_start    <= '0;
      eye_len_o     <= '0;
      eye_start_o   <= '0;
      iserdes_rst_o <= 1'b0;
      idelay_load_o <= 1'b0;
      bitslip_o     <= 1'b0;
      busy_o        <= 1'b0;
      locked_o      <= 1'b0;
      fail_o        <= 1'b0;
`ifdef COUT_ALIGN_EYE_MAP_EN
      map           <= '0;
`endif
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      tap           <= tap_n;
      slips         <= slips_n;
      ref_nyb       <= ref_nyb_n;
      ok            <= ok_n;
      cur_len       <= cur_len_n;
      cur_start     <= cur_start_n;
      best_len      <= best_len_n;
      best_start    <= best_start_n;
      eye_len_o     <= eye_len_n;
      eye_start_o   <= eye_start_n;
      iserdes_rst_o <= (state_n == RST);
      idelay_load_o <= (state_n == LOAD) || (state_n == CLOAD);
      bitslip_o     <= (state_n == SLIP);
      busy_o        <= !(state_n inside {IDLE, LOCKED, FAIL});
      locked_o      <= (state_n == LOCKED);
      fail_o        <= (state_n == FAIL);
`ifdef COUT_ALIGN_EYE_MAP_EN
      map           <= map_n;
`endif
    end
  end

  assign idelay_value_o = tap;
`ifdef COUT_ALIGN_EYE_MAP_EN
  assign eye_map_o = map;
`else
  assign eye_map_o = 32'h0;
`endif

endmodule

// File: tb/tb_surf_cout_align_ctrl.sv
// Scoreboard bench for surf_cout_align_ctrl: a behavioural lane model answers IDELAY taps and bitslips.
module tb_surf_cout_align_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sync;
  logic        sync_man = 1'b0;
  logic        sync_auto_v = 1'b0;
  bit          sync_auto = 1'b1;
  logic [3:0]  cout = 4'h0;
  logic        iserdes_rst, idelay_load, bitslip, busy, locked, fail;
  logic [4:0]  idelay_value, eye_start;
  logic [5:0]  eye_len;
  logic [31:0] eye_map;
  logic [53:0] all_out;

  int checks = 0;
  int fails  = 0;
  int cyc = 0, nload = 0, nslip = 0, last_load = 0, load_gap = 0, slip_base = 0;
  logic [4:0]  phy_tap = '0;
  logic [31:0] pass_mask = '0;
  logic [3:0]  val_pre = 4'hC, val_post = 4'hC;
  bit excl_bad = 1'b0, lf_bad = 1'b0;

  typedef struct {
    logic [25:0] res;
    logic [31:0] map;
  } exp_t;
  exp_t exp_q[$];

  assign sync = sync_auto ? sync_auto_v : sync_man;
  assign all_out = {iserdes_rst, idelay_value, idelay_load, bitslip, busy, locked, fail,
                    eye_start, eye_len, eye_map};

  surf_cout_align_ctrl dut (
    .sysclk_i       (clk),
    .rst_i          (rst),
    .start_i        (start),
    .sync_i         (sync),
    .cout_i         (cout),
    .iserdes_rst_o  (iserdes_rst),
    .idelay_value_o (idelay_value),
    .idelay_load_o  (idelay_load),
    .bitslip_o      (bitslip),
    .busy_o         (busy),
    .locked_o       (locked),
    .fail_o         (fail),
    .eye_start_o    (eye_start),
    .eye_len_o      (eye_len),
    .eye_map_o      (eye_map)
  );

  always #5 clk = ~clk;

  // Lane model: passing taps return the pattern (pre/post first bitslip), other taps toggle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (idelay_load) begin
        phy_tap   = idelay_value;
        nload++;
        load_gap  = cyc - last_load;
        last_load = cyc;
      end
      if (bitslip) nslip++;
      if (int'(iserdes_rst) + int'(idelay_load) + int'(bitslip) > 1) excl_bad = 1'b1;
      if (locked && fail) lf_bad = 1'b1;
      sync_auto_v = (cyc % 8 == 0);
      if (pass_mask[phy_tap]) cout = (nslip - slip_base == 0) ? val_pre : val_post;
      else                    cout = (cyc % 2 == 1) ? 4'hC : 4'h3;
    end
  end

  function automatic logic [25:0] pack(input logic lk, input logic fl, input logic [4:0] es,
                                       input logic [5:0] el, input logic [4:0] tp, input int sl);
    return {lk, fl, es, el, tp, 8'(sl)};
  endfunction

  function automatic logic [31:0] exp_map(input logic [31:0] m);
`ifdef COUT_ALIGN_EYE_MAP_EN
    return m;
`else
    return 32'h0;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic launch();
    slip_base = nslip;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_scan(input logic [31:0] m, input logic [3:0] pre, input logic [3:0] post,
                          output bit to);
    pass_mask = m;
    val_pre   = pre;
    val_post  = post;
    launch();
    to = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      step();
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (all_out !== 54'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (all_out !== 54'h0) begin
      fails++;
      $display("FAIL idle_outputs: got %h want 0", all_out);
    end
  endtask

  task automatic test_clean_eye();
    exp_t e;
    bit to;
    int lb;
    logic [25:0] obs;
    pass_mask = 32'h001FFC00;
    val_pre   = 4'hC;
    val_post  = 4'hC;
    e.res = pack(1'b1, 1'b0, 5'd10, 6'd11, 5'd15, 0);
    e.map = exp_map(pass_mask);
    exp_q.push_back(e);
    lb = nload;
    sync_auto = 1'b0;
    sync_man  = 1'b1;
    launch();
    sync_man = 1'b0;
    repeat (12) step();
    checks++;
    if (nload - lb !== 0) begin
      fails++;
      $display("FAIL sync_with_start: loads %0d want 0", nload - lb);
    end
    sync_man = 1'b1;
    step();
    sync_man  = 1'b0;
    sync_auto = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      step();
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      fails++;
      $display("FAIL clean_timeout: busy still %b want 0", busy);
    end
    e = exp_q.pop_front();
    obs = pack(locked, fail, eye_start, eye_len, idelay_value, nslip - slip_base);
    checks++;
    if (obs !== e.res) begin
      fails++;
      $display("FAIL clean_result: got %h want %h", obs, e.res);
    end
    checks++;
    if (eye_map !== e.map) begin
      fails++;
      $display("FAIL clean_map: got %h want %h", eye_map, e.map);
    end
    checks++;
    if (nload - lb !== 33) begin
      fails++;
      $display("FAIL clean_loads: got %0d want 33", nload - lb);
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    bit to;
    logic [25:0] obs;
    e.res = pack(1'b1, 1'b0, 5'd4, 6'd8, 5'd7, 1);
    e.map = exp_map(32'h00000FF0);
    exp_q.push_back(e);
    run_scan(32'h00000FF0, 4'h6, 4'hC, to);
    e = exp_q.pop_front();
    obs = pack(locked, fail, eye_start, eye_len, idelay_value, nslip - slip_base);
    checks++;
    if (to || obs !== e.res) begin
      fails++;
      $display("FAIL rotation_result: got %h want %h timeout %b", obs, e.res, to);
    end
    checks++;
    if (eye_map !== e.map) begin
      fails++;
      $display("FAIL rotation_map: got %h want %h", eye_map, e.map);
    end
  endtask

  task automatic test_two_eyes();
    exp_t e;
    bit to;
    logic [25:0] obs;
    e.res = pack(1'b1, 1'b0, 5'd0, 6'd6, 5'd2, 0);
    e.map = exp_map(32'h03F0003F);
    exp_q.push_back(e);
    e.res = pack(1'b1, 1'b0, 5'd20, 6'd7, 5'd23, 0);
    e.map = exp_map(32'h07F0003F);
    exp_q.push_back(e);
    run_scan(32'h03F0003F, 4'hC, 4'hC, to);
    e = exp_q.pop_front();
    obs = pack(locked, fail, eye_start, eye_len, idelay_value, nslip - slip_base);
    checks++;
    if (to || obs !== e.res) begin
      fails++;
      $display("FAIL tie_result: got %h want %h timeout %b", obs, e.res, to);
    end
    checks++;
    if (eye_map !== e.map) begin
      fails++;
      $display("FAIL tie_map: got %h want %h", eye_map, e.map);
    end
    run_scan(32'h07F0003F, 4'hC, 4'hC, to);
    e = exp_q.pop_front();
    obs = pack(locked, fail, eye_start, eye_len, idelay_value, nslip - slip_base);
    checks++;
    if (to || obs !== e.res) begin
      fails++;
      $display("FAIL longer_result: got %h want %h timeout %b", obs, e.res, to);
    end
  endtask

  task automatic test_narrow();
    exp_t e;
    bit to;
    logic [25:0] obs;
    e.res = pack(1'b0, 1'b1, 5'd8, 6'd3, 5'd31, 0);
    e.map = exp_map(32'h00000700);
    exp_q.push_back(e);
    run_scan(32'h00000700, 4'hC, 4'hC, to);
    e = exp_q.pop_front();
    obs = pack(locked, fail, eye_start, eye_len, idelay_value, nslip - slip_base);
    checks++;
    if (to || obs !== e.res) begin
      fails++;
      $display("FAIL narrow_result: got %h want %h timeout %b", obs, e.res, to);
    end
    checks++;
    if (eye_map !== e.map) begin
      fails++;
      $display("FAIL narrow_map: got %h want %h", eye_map, e.map);
    end
  endtask

  task automatic test_no_match();
    exp_t e;
    bit to;
    logic [25:0] obs;
    e.res = pack(1'b0, 1'b1, 5'd10, 6'd11, 5'd15, 3);
    e.map = exp_map(32'h001FFC00);
    exp_q.push_back(e);
    run_scan(32'h001FFC00, 4'h3, 4'h3, to);
    e = exp_q.pop_front();
    obs = pack(locked, fail, eye_start, eye_len, idelay_value, nslip - slip_base);
    checks++;
    if (to || obs !== e.res) begin
      fails++;
      $display("FAIL noslip_result: got %h want %h timeout %b", obs, e.res, to);
    end
  endtask

  task automatic test_reset_midscan();
    bit found;
    int k;
    int lb;
    pass_mask = 32'h001FFC00;
    val_pre   = 4'hC;
    val_post  = 4'hC;
    launch();
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (idelay_load && idelay_value == 5'd5) begin
        found = 1'b1;
        break;
      end
    end
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      if (i == 30) start = 1'b1;
      if (i == 31) start = 1'b0;
      step();
      if (idelay_load) begin
        k = i;
        break;
      end
    end
    checks++;
    if (!found || k !== 82 || idelay_value !== 5'd6) begin
      fails++;
      $display("FAIL busy_start_gap: gap %0d tap %0d want 82 tap 6", k, idelay_value);
    end
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (idelay_load && idelay_value == 5'd17) begin
        found = 1'b1;
        break;
      end
    end
    repeat (30) step();
    checks++;
    if (!found || busy !== 1'b1) begin
      fails++;
      $display("FAIL tap17_busy: busy %b found %b want 1", busy, found);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (all_out !== 54'h0) begin
      fails++;
      $display("FAIL async_reset: got %h want 0", all_out);
    end
    rst = 1'b0;
    lb = nload;
    repeat (6) step();
    checks++;
    if (all_out !== 54'h0 || nload - lb !== 0) begin
      fails++;
      $display("FAIL post_reset_idle: got %h loads %0d want 0", all_out, nload - lb);
    end
    launch();
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_accept: busy %b want 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_strobes();
    checks++;
    if (excl_bad !== 1'b0) begin
      fails++;
      $display("FAIL strobe_exclusive: overlap %b want 0", excl_bad);
    end
    checks++;
    if (lf_bad !== 1'b0) begin
      fails++;
      $display("FAIL locked_and_fail: both %b want 0", lf_bad);
    end
  endtask

  initial begin
    test_reset();
    test_clean_eye();
    test_rotation();
    test_two_eyes();
    test_narrow();
    test_no_match();
    test_reset_midscan();
    test_strobes();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/surf_cout_align_ctrl.md
# surf_cout_align_ctrl

Training controller for one SURF COUT receive lane. It sequences the lane's ISERDES reset, IDELAY load and bitslip controls to find the centre of the data eye and nybble alignment against a fixed 4-bit training pattern. It then reports lock to the TURFIO register/control logic. It sits between the control registers and the COUT PHY, in the sysclk domain.

## Interface
Parameters:
- TRAIN_PATTERN, 4'hC: expected nybble when aligned; all four rotations must be distinct.
- SETTLE_CYCLES, 16: wait after each IDELAY load, range 1–255.
- CHECK_CYCLES, 64: compare window per tap, range 1–1023.
- MIN_EYE, 4: minimum passing-tap run to accept, range 1–32.

Ports:
- sysclk_i  in  1  system clock; every register is in this domain.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  pulse; begins training.
- sync_i  in  1  sysclk phase marker (the `dout_sync` qualifier).
- cout_i  in  4  parallel COUT nybble from the PHY.
- iserdes_rst_o  out  1  ISERDES reset request.
- idelay_value_o  out  5  IDELAY tap value.
- idelay_load_o  out  1  IDELAY load strobe.
- bitslip_o  out  1  bitslip strobe.
- busy_o  out  1  training in progress.
- locked_o  out  1  training succeeded.
- fail_o  out  1  training failed.
- eye_start_o  out  5  first tap of the chosen eye.
- eye_len_o  out  6  length of the chosen eye, 0–32.
- eye_map_o  out  32  per-tap pass bitmap.

## Operation
State machine states: IDLE, RST, WAIT_SYNC, LOAD, SETTLE, CHECK, NEXT, CALC, CLOAD, CSETTLE, SCHECK, SLIP, SWAIT, LOCKED, FAIL.

- **Start:** start_i is accepted only in IDLE, LOCKED or FAIL. It is ignored otherwise.
- **On start:** clear locked_o, fail_o, the run trackers and the eye map. Go to RST.
- **RST:** assert iserdes_rst_o for exactly one cycle, then go to WAIT_SYNC.
- **WAIT_SYNC:** wait for sync_i = 1. Set tap = 0, then go to LOAD.
- **LOAD:** assert idelay_load_o for one cycle with idelay_value_o = tap, then go to SETTLE.
- **SETTLE:** count SETTLE_CYCLES cycles, then go to CHECK.
- **CHECK:** sample cout_i for CHECK_CYCLES cycles.
  - The tap passes if every sample equals some rotation of TRAIN_PATTERN and all samples are identical.
  - A mismatch does not end the window early, so the time spent per tap is fixed.
- **NEXT:** update the run trackers.
  - On pass: `cur_len++`; if cur_len was 0, `cur_start = tap`.
  - On fail: `cur_len = 0`.
  - When the new cur_len is strictly greater than best_len, copy the current run into best. Ties therefore keep the earliest run.
  - The run does not wrap from tap 31 to tap 0.
  - If tap = 31, go to CALC; otherwise `tap++` and go to LOAD.
- **CALC:**
  - If best_len < MIN_EYE, go to FAIL.
  - Otherwise set `tap = best_start + (best_len-1)>>1` (5-bit result, cannot overflow) and go to CLOAD.
- **CLOAD / CSETTLE:** same behaviour as LOAD / SETTLE. Then go to SCHECK with `slips = 0`.
- **SCHECK:** run one CHECK_CYCLES window with exact comparison `cout_i == TRAIN_PATTERN`.
  - All samples match: go to LOCKED.
  - Otherwise, if slips = 3, go to FAIL.
  - Otherwise go to SLIP.
- **SLIP:** one-cycle bitslip_o pulse, `slips++`, then go to SWAIT.
- **SWAIT:** wait 4 cycles, then return to SCHECK.
- **LOCKED / FAIL:** hold all outputs until the next start_i.

## Timing
- **Reset values:** every output is 0; the state is IDLE.
- **Asynchronous reset mid-training:** forces the reset values immediately. The partial scan is discarded.
- **Strobes:** iserdes_rst_o, idelay_load_o and bitslip_o are single-cycle, registered, and mutually exclusive.
- **idelay_value_o:** is valid on the cycle the load strobe is high and is held afterwards.
- **busy_o:** is 1 from the cycle after start_i is accepted until the cycle LOCKED or FAIL is entered.
- **locked_o / fail_o:** assert in the same cycle busy_o falls, and never both together.
- **Per-tap scan time:** 1 + SETTLE_CYCLES + CHECK_CYCLES + 1 cycles.
- **eye_start_o / eye_len_o:** update in CALC and are held until the next start.
- **start_i and sync_i together in IDLE:** the sync_i is not consumed. WAIT_SYNC waits for a later sync_i.
- **start_i while busy:** has no effect.

## Configuration
- **COUT_ALIGN_EYE_MAP_EN defined:**
  - Bit[tap] of a 32-bit register is written in NEXT with the pass result.
  - eye_map_o presents this register.
  - The register is cleared on start and on reset.
- **COUT_ALIGN_EYE_MAP_EN undefined:**
  - The register is not built and eye_map_o is constant 0.
  - Centre selection is identical, because it uses only the online run trackers.

## Test plan
- **Clean eye, correct alignment:** cout_i = 4'hC for taps 10–20 and noise elsewhere → eye_start_o = 10, eye_len_o = 11, final idelay_value_o = 15, no bitslip pulses, locked_o = 1.
- **Nybble rotation:** passing taps 4–11 with cout_i = 4'h6 until one bitslip, then 4'hC → centre tap 7, exactly one bitslip_o, locked_o = 1.
- **Two eyes:** taps 0–5 pass and taps 20–25 pass (equal length) → eye_start_o = 0, centre tap 2. Repeat with taps 20–26 passing → eye_start_o = 20, centre tap 23.
- **Eye too narrow:** taps 8–10 pass with MIN_EYE = 4 → fail_o = 1, eye_len_o = 3, no bitslip issued.
- **Bitslip never matches:** cout_i held at 4'h3 after the centre load → exactly 3 bitslip pulses, then fail_o = 1.
- **Reset and ignored start:** assert rst_i during tap 17 CHECK → all outputs 0 the next cycle and state IDLE. A start_i while busy_o = 1 leaves the scan timing unchanged. With COUT_ALIGN_EYE_MAP_EN defined, the clean-eye case gives eye_map_o = 32'h001FFC00.
